// File: rtl/apb_pkg.sv
// Shared APB definitions for the completer slice: bus widths, FSM states,
// reset constants and the address range helper.
package apb_pkg;

  localparam int APB_ADDR_W = 9;
  localparam int APB_DATA_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam logic [APB_DATA_W-1:0] PRDATA_RST  = '0;
  localparam logic                  PREADY_RST  = 1'b0;
  localparam logic                  PSLVERR_RST = 1'b0;

  function automatic logic addr_ok(input logic [7:0] addr, input int unsigned depth);
    return 32'(addr) < depth;
  endfunction

endpackage

// File: rtl/apb_regfile.sv
// Byte-wide register file: synchronous write, combinational read,
// synchronous parallel clear on rst. Out-of-range reads return zero.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [7:0]            waddr,
  input  logic [APB_DATA_W-1:0] wdata,
  input  logic [7:0]            raddr,
  output logic [APB_DATA_W-1:0] rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [APB_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[IW'(i)] <= '0;
      end
    end else if (we && addr_ok(waddr, DEPTH)) begin
      mem[waddr[IW-1:0]] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (addr_ok(raddr, DEPTH)) begin
      rdata = mem[raddr[IW-1:0]];
    end
  end

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer with a byte register file, programmable wait states and
// PSLVERR on out-of-range addresses or control changes mid-transfer.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [APB_ADDR_W-1:0] PADDR,
  input  logic [APB_DATA_W-1:0] PWDATA,
  output logic [APB_DATA_W-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  PROT_ERR
);

  apb_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [7:0]            addr_q;
  logic                  write_q;
  logic [APB_DATA_W-1:0] wdata_q;
  logic [APB_DATA_W-1:0] rdata_q;
  logic                  prot_q, prot_d;
  logic                  setup;
  logic                  we;
  logic                  err_cmp;
  logic [APB_DATA_W-1:0] mem_rdata;
  logic                  unused_paddr_msb;

  // PADDR[8] is decoded upstream to pick between slave instances.
  assign unused_paddr_msb = PADDR[8];

  assign err_cmp = !addr_ok(addr_q, DEPTH)
                 || (PADDR[7:0] != addr_q)
                 || (PWRITE != write_q)
                 || (write_q && (PWDATA != wdata_q));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prot_d  = 1'b0;
    setup   = 1'b0;
    we      = 1'b0;
    PREADY  = PREADY_RST;
    PSLVERR = PSLVERR_RST;
    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          setup   = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ACCESS;
        end else if (PSEL && PENABLE) begin
          prot_d = 1'b1;
        end
      end
      ACCESS: begin
        PREADY = (cnt_q == '0) && PSEL && PENABLE;
        if (!PSEL || !PENABLE) begin
          prot_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          PSLVERR = err_cmp;
          we      = write_q && !err_cmp;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= PRDATA_RST;
      prot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prot_q  <= prot_d;
      if (setup) begin
        addr_q  <= PADDR[7:0];
        write_q <= PWRITE;
        wdata_q <= PWDATA;
        if (!PWRITE) begin
          rdata_q <= mem_rdata;
        end
      end
    end
  end

  // Read data is held from setup; only an erroring read completion masks it.
  assign PRDATA   = (PSLVERR && !write_q) ? '0 : rdata_q;
  assign PROT_ERR = prot_q;

  apb_regfile #(
    .DEPTH(DEPTH)
  ) u_regfile (
    .clk  (PCLK),
    .rst  (PRESET),
    .we   (we),
    .waddr(addr_q),
    .wdata(wdata_q),
    .raddr(PADDR[7:0]),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Randomized self-checking bench for apb_slave_mem: one instance with two
// wait states and one with none, each against a byte-array reference model.
module tb_apb_slave_mem;

  localparam int DEPTH = 64;

  logic       PCLK;
  logic [1:0] preset, psel, penable, pwrite;
  logic [8:0] paddr  [2];
  logic [7:0] pwdata [2];
  logic [7:0] prdata [2];
  logic [1:0] pready, pslverr, prot_err;

  logic [7:0] model [2][DEPTH];
  int vectors    = 0;
  int miscompares = 0;

  apb_slave_mem #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut0 (
    .PCLK(PCLK), .PRESET(preset[0]), .PSEL(psel[0]), .PENABLE(penable[0]),
    .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]),
    .PROT_ERR(prot_err[0])
  );

  apb_slave_mem #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut1 (
    .PCLK(PCLK), .PRESET(preset[1]), .PSEL(psel[1]), .PENABLE(penable[1]),
    .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]),
    .PROT_ERR(prot_err[1])
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic logic [7:0] exp_read(input int d, input logic [8:0] a);
    if (int'(a[7:0]) < DEPTH) return model[d][a[7:0]];
    return 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_model(input int d);
    for (int i = 0; i < DEPTH; i++) model[d][i] = 8'h00;
  endtask

  task automatic idle(input int d, input int n);
    repeat (n) begin
      @(posedge PCLK); #1;
      psel[d] = 1'b0; penable[d] = 1'b0;
      @(negedge PCLK);
      chk("idle_ready", 32'(pready[d]), 0);
      chk("idle_slverr", 32'(pslverr[d]), 0);
    end
  endtask

  // mode: 0 clean, 1 PWDATA ^ 8'h33, 2 PADDR[0] flip, 3 PWRITE flip,
  // 4 PADDR[8] flip (ignored by the slave). Mutations land in access cycle 2.
  task automatic xfer(input int d, input logic wr, input logic [8:0] a,
                      input logic [7:0] wd, input int mode);
    int         w;
    logic       err;
    logic [7:0] rexp;
    w    = wait_of(d);
    err  = (int'(a[7:0]) >= DEPTH) || (mode == 2) || (mode == 3) || (mode == 1 && wr);
    rexp = exp_read(d, a);
    @(posedge PCLK); #1;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    @(negedge PCLK);
    chk("setup_ready", 32'(pready[d]), 0);
    chk("setup_slverr", 32'(pslverr[d]), 0);
    @(posedge PCLK); #1;
    penable[d] = 1'b1;
    for (int n = 1; n <= w + 1; n++) begin
      if (n > 1) begin
        @(posedge PCLK); #1;
        if (n == 2) begin
          case (mode)
            1: pwdata[d] = wd ^ 8'h33;
            2: paddr[d]  = a ^ 9'h001;
            3: pwrite[d] = ~wr;
            4: paddr[d]  = a ^ 9'h100;
            default: ;
          endcase
        end
      end
      @(negedge PCLK);
      chk("access_ready", 32'(pready[d]), 32'(n == w + 1));
      chk("access_slverr", 32'(pslverr[d]), 32'((n == w + 1) && err));
      chk("access_prot", 32'(prot_err[d]), 0);
      if (!wr) chk("read_data", 32'(prdata[d]), 32'(((n == w + 1) && err) ? 8'h00 : rexp));
    end
    if (wr && !err) model[d][a[7:0]] = wd;
  endtask

  task automatic random_run(input int d, input int count);
    logic       wr;
    logic [8:0] a;
    int         mode;
    for (int k = 0; k < count; k++) begin
      wr   = 1'($urandom_range(0, 1));
      a    = 9'($urandom_range(0, 71)) | (9'($urandom_range(0, 1)) << 8);
      mode = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      if (wait_of(d) == 0 || (mode == 1 && !wr)) mode = 0;
      xfer(d, wr, a, 8'($urandom), mode);
      if ($urandom_range(0, 2) == 0) idle(d, $urandom_range(1, 2));
    end
  endtask

  initial begin
    preset = 2'b11; psel = '0; penable = '0; pwrite = '0;
    for (int d = 0; d < 2; d++) begin
      paddr[d] = '0; pwdata[d] = '0;
      clear_model(d);
    end
    repeat (2) @(posedge PCLK);
    #1 preset = 2'b00;
    @(negedge PCLK);
    for (int d = 0; d < 2; d++) begin
      chk("rst_prdata", 32'(prdata[d]), 0);
      chk("rst_ready", 32'(pready[d]), 0);
      chk("rst_slverr", 32'(pslverr[d]), 0);
      chk("rst_prot", 32'(prot_err[d]), 0);
    end

    for (int i = 0; i < DEPTH; i++) xfer(0, 1'b0, 9'(i), 8'h00, 0);

    xfer(0, 1'b1, 9'd5, 8'hA5, 0);
    xfer(0, 1'b0, 9'd5, 8'h00, 0);
    idle(0, 1);

    xfer(0, 1'b1, 9'd64, 8'h3C, 0);
    xfer(0, 1'b0, 9'd0, 8'h00, 0);
    xfer(0, 1'b0, 9'd63, 8'h00, 0);

    xfer(0, 1'b1, 9'd3, 8'h5A, 0);
    xfer(0, 1'b1, 9'd3, 8'h11, 1);
    xfer(0, 1'b0, 9'd3, 8'h00, 0);
    idle(0, 1);

    // Access phase from IDLE with no setup.
    @(posedge PCLK); #1;
    psel[0] = 1'b1; penable[0] = 1'b1; paddr[0] = 9'd3;
    @(negedge PCLK);
    chk("nosetup_ready", 32'(pready[0]), 0);
    @(posedge PCLK); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge PCLK);
    chk("nosetup_prot", 32'(prot_err[0]), 1);
    chk("nosetup_ready2", 32'(pready[0]), 0);
    @(negedge PCLK);
    chk("nosetup_prot_end", 32'(prot_err[0]), 0);

    // PSEL dropped during the access phase of a write.
    @(posedge PCLK); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 9'd9; pwdata[0] = 8'h77;
    @(posedge PCLK); #1;
    penable[0] = 1'b1;
    @(posedge PCLK); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge PCLK);
    chk("abort_prot_low", 32'(prot_err[0]), 0);
    @(negedge PCLK);
    chk("abort_prot", 32'(prot_err[0]), 1);
    chk("abort_ready", 32'(pready[0]), 0);
    @(negedge PCLK);
    chk("abort_prot_end", 32'(prot_err[0]), 0);
    xfer(0, 1'b0, 9'd9, 8'h00, 0);

    // PENABLE never raised after setup.
    @(posedge PCLK); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 9'd9; pwdata[0] = 8'h66;
    @(posedge PCLK); #1;
    @(negedge PCLK);
    chk("noen_ready", 32'(pready[0]), 0);
    @(posedge PCLK); #1;
    psel[0] = 1'b0;
    @(negedge PCLK);
    chk("noen_prot", 32'(prot_err[0]), 1);
    idle(0, 1);
    xfer(0, 1'b0, 9'd9, 8'h00, 0);

    random_run(0, 300);

    // Reset in the middle of a write's access phase.
    xfer(0, 1'b1, 9'd10, 8'h99, 0);
    @(posedge PCLK); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 9'd10; pwdata[0] = 8'h42;
    @(posedge PCLK); #1;
    penable[0] = 1'b1;
    @(posedge PCLK); #1;
    preset[0] = 1'b1;
    @(posedge PCLK); #1;
    preset[0] = 1'b0; psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge PCLK);
    chk("rst_mid_ready0", 32'(pready[0]), 0);
    clear_model(0);
    xfer(0, 1'b0, 9'd10, 8'h00, 0);
    xfer(0, 1'b0, 9'd5, 8'h00, 0);

    xfer(1, 1'b1, 9'd7, 8'hC3, 0);
    xfer(1, 1'b0, 9'd7, 8'h00, 0);
    xfer(1, 1'b1, 9'd63, 8'h1E, 0);
    xfer(1, 1'b1, 9'd64, 8'hE1, 0);
    xfer(1, 1'b0, 9'd63, 8'h00, 0);
    random_run(1, 80);

    xfer(1, 1'b1, 9'd7, 8'hC3, 0);
    @(posedge PCLK); #1;
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 9'd7; pwdata[1] = 8'h44;
    @(posedge PCLK); #1;
    penable[1] = 1'b1; preset[1] = 1'b1;
    @(posedge PCLK); #1;
    preset[1] = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
    @(negedge PCLK);
    chk("rst_mid_ready1", 32'(pready[1]), 0);
    clear_model(1);
    xfer(1, 1'b0, 9'd7, 8'h00, 0);
    idle(1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
